counter_seq_ctrl: RTL and testbench

- Controller that sequences a free-running up-counter datapath as a programmable period timer.
- Accepts start/stop/pause commands from a single requester.
- Latches a period and mode, and drives the counter through one-shot or periodic runs.
- Reports terminal count with a single-cycle done pulse.
- Sits between software-facing control logic and the counter datapath.

---
 rtl/counter_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Sequences an up-counter as a programmable period timer. A single requester
//   issues start/stop/pause. Period and mode are latched at start. The block runs
//   one-shot or periodic and flags each terminal count with a 1-cycle done pulse.
//
//   Optional build macro: COUNTER_SEQ_CTRL_PRESCALE_EN
//     When it is defined, the block gains a `prescale` input, and a count tick
//     occurs once every prescale+1 clocks. When it is undefined, a tick occurs
//     every clock and the block has no prescaler registers.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start          start request (IDLE only)
//   stop           abort current run
//   pause          level, hold count while high during a run
//   mode_periodic  0 one-shot / 1 periodic, latched at start
//   period         ticks per run, latched at start, 0 rejected
//   prescale       (optional) tick divider, sampled continuously
//   start_ack      1-cycle pulse, start accepted
//   err            1-cycle pulse, start rejected (period == 0)
//   busy           high in RUN or PAUSED
//   count          current count, 0..period-1
//   done           1-cycle pulse on terminal count
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode_periodic,
  input  logic [WIDTH-1:0] period,
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  input  logic [PRE_W-1:0] prescale,
`endif
  output logic             start_ack,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_d;
  logic [WIDTH-1:0] count_d, period_q, period_d;
  logic             mode_q, mode_d;
  logic             ack_d, err_d, done_d;
  logic             tick;

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  localparam logic [PRE_W-1:0] PONE = PRE_W'(1);
  logic [PRE_W-1:0] pre_cnt, pre_d;
  // Use >= rather than == so that lowering prescale mid-run cannot strand the
  // counter above the new limit.
  assign tick = (pre_cnt >= prescale);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state;
    count_d  = count;
    period_d = period_q;
    mode_d   = mode_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    pre_d    = pre_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (period == '0) begin
            err_d = 1'b1;
          end else begin
            state_d  = RUN;
            period_d = period;
            mode_d   = mode_periodic;
            count_d  = '0;
            ack_d    = 1'b1;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
            pre_d    = '0;
`endif
          end
        end
      end
      RUN, PAUSED: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
          pre_d   = '0;
`endif
        end else if (pause) begin
          // Hold count and prescaler. A terminal tick here is not taken.
          state_d = PAUSED;
        end else begin
          // Releasing pause counts on the same edge. This way, N paused cycles
          // delay done by exactly N.
          state_d = RUN;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
          pre_d   = tick ? '0 : pre_cnt + PONE;
`endif
          if (tick) begin
            if (count == period_q - ONE) begin
              count_d = '0;
              done_d  = 1'b1;
              if (!mode_q) state_d = IDLE;
            end else begin
              count_d = count + ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      period_q  <= '0;
      mode_q    <= 1'b0;
      start_ack <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
      pre_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      count     <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      start_ack <= ack_d;
      err       <= err_d;
      done      <= done_d;
      busy      <= (state_d != IDLE);
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
      pre_cnt   <= pre_d;
`endif
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl (WIDTH=4). Each scenario is a table
// of per-cycle stimulus rows. Each row carries the outputs expected after the
// edge that consumes it. The expected outputs are queued when the row is driven
// and compared once the DUT has registered the row.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, mode_periodic;
  logic [3:0] period;
  logic       start_ack, err, busy, done;
  logic [3:0] count;
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  logic [7:0] prescale = 8'd0;
`endif

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(4), .PRE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode_periodic(mode_periodic), .period(period),
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    .prescale(prescale),
`endif
    .start_ack(start_ack), .err(err), .busy(busy), .count(count), .done(done)
  );

  // Observation vector: {start_ack, err, busy, done, count[3:0]}
  typedef logic [7:0] obs_t;
  typedef struct packed {
    logic       rst, start, stop, pause, mode;
    logic [3:0] period;
    obs_t       exp;
  } row_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic row_t mk(input bit rs, s, sp, p, m, input int per,
                              input bit a, e, b, d, input int c);
    row_t r;
    r.rst = rs; r.start = s; r.stop = sp; r.pause = p; r.mode = m;
    r.period = 4'(per);
    r.exp = {a, e, b, d, 4'(c)};
    return r;
  endfunction

  // Drive one row, queue its expectation, and let one edge consume it.
  task automatic apply(input row_t r);
    rst = r.rst; start = r.start; stop = r.stop; pause = r.pause;
    mode_periodic = r.mode; period = r.period;
    exp_q.push_back(r.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t r[$]; obs_t e, o;
    r.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0));
    r.push_back(mk(1,1,1,1,1,5, 0,0,0,0,0));   // reset beats start
    // Reset mid-run: period 5 one-shot, reset when count==3
    r.push_back(mk(0,1,0,0,0,5, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,5, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,5, 0,0,1,0,2));
    r.push_back(mk(0,0,0,0,0,5, 0,0,1,0,3));
    r.push_back(mk(1,0,0,0,0,5, 0,0,0,0,0));
    r.push_back(mk(0,0,0,0,0,5, 0,0,0,0,0));
    r.push_back(mk(0,0,0,0,0,5, 0,0,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); e = exp_q.pop_front(); o = {start_ack, err, busy, done, count};
      total++;
      if (o !== e) begin bad++; $display("FAIL reset step %0d got(ack,err,busy,done,cnt)=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_oneshot();
    row_t r[$]; obs_t e, o;
    r.push_back(mk(0,1,0,0,0,3, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,9, 0,0,1,0,1));   // period input no longer matters
    r.push_back(mk(0,0,0,0,0,9, 0,0,1,0,2));
    r.push_back(mk(0,0,0,0,0,9, 0,0,0,1,0));
    r.push_back(mk(0,0,0,0,0,9, 0,0,0,0,0));
    r.push_back(mk(0,0,0,0,0,9, 0,0,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); e = exp_q.pop_front(); o = {start_ack, err, busy, done, count};
      total++;
      if (o !== e) begin bad++; $display("FAIL oneshot step %0d got(ack,err,busy,done,cnt)=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_periodic();
    row_t r[$]; obs_t e, o;
    r.push_back(mk(0,1,0,0,1,4, 1,0,1,0,0));
    for (int k = 0; k < 3; k++) begin
      r.push_back(mk(0,0,0,0,0,4, 0,0,1,0,1));
      r.push_back(mk(0,0,0,0,0,4, 0,0,1,0,2));
      r.push_back(mk(0,0,0,0,0,4, 0,0,1,0,3));
      r.push_back(mk(0,0,0,0,0,4, 0,0,1,1,0));
    end
    r.push_back(mk(0,0,0,0,0,4, 0,0,1,0,1));
    r.push_back(mk(0,0,1,0,0,4, 0,0,0,0,0));   // stop
    r.push_back(mk(0,0,0,0,0,4, 0,0,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); e = exp_q.pop_front(); o = {start_ack, err, busy, done, count};
      total++;
      if (o !== e) begin bad++; $display("FAIL periodic step %0d got(ack,err,busy,done,cnt)=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_pause();
    row_t r[$]; obs_t e, o;
    r.push_back(mk(0,1,0,0,0,6, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,6, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,6, 0,0,1,0,2));
    r.push_back(mk(0,0,0,1,0,6, 0,0,1,0,2));
    r.push_back(mk(0,1,0,1,1,2, 0,0,1,0,2));   // start while paused ignored
    r.push_back(mk(0,0,0,1,0,6, 0,0,1,0,2));
    r.push_back(mk(0,0,0,0,0,6, 0,0,1,0,3));
    r.push_back(mk(0,0,0,0,0,6, 0,0,1,0,4));
    r.push_back(mk(0,0,0,0,0,6, 0,0,1,0,5));
    r.push_back(mk(0,0,0,0,0,6, 0,0,0,1,0));   // 6 + 3 edges after start
    r.push_back(mk(0,0,0,0,0,6, 0,0,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); e = exp_q.pop_front(); o = {start_ack, err, busy, done, count};
      total++;
      if (o !== e) begin bad++; $display("FAIL pause step %0d got(ack,err,busy,done,cnt)=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_boundaries();
    row_t r[$]; obs_t e, o;
    // period 0 rejected; stop/pause ignored in IDLE
    r.push_back(mk(0,1,0,0,0,0, 0,1,0,0,0));
    r.push_back(mk(0,0,1,1,0,0, 0,0,0,0,0));
    // stop on the terminal tick: no done
    r.push_back(mk(0,1,0,0,0,3, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,3, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,3, 0,0,1,0,2));
    r.push_back(mk(0,0,1,0,0,3, 0,0,0,0,0));
    r.push_back(mk(0,0,0,0,0,3, 0,0,0,0,0));
    // pause on the terminal tick (periodic): holds at period-1
    r.push_back(mk(0,1,0,0,1,3, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,3, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,3, 0,0,1,0,2));
    r.push_back(mk(0,0,0,1,0,3, 0,0,1,0,2));
    r.push_back(mk(0,0,0,1,0,3, 0,0,1,0,2));
    r.push_back(mk(0,0,0,0,0,3, 0,0,1,1,0));
    r.push_back(mk(0,0,1,1,0,3, 0,0,0,0,0));   // stop beats pause
    // start during RUN ignored; period 3 one-shot still governs
    r.push_back(mk(0,1,0,0,0,3, 1,0,1,0,0));
    r.push_back(mk(0,1,0,0,1,7, 0,0,1,0,1));
    r.push_back(mk(0,1,0,0,1,0, 0,0,1,0,2));
    r.push_back(mk(0,0,0,0,0,7, 0,0,0,1,0));
    // period 1: done on every tick; back-to-back start right after done
    r.push_back(mk(0,1,0,0,1,1, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,1, 0,0,1,1,0));
    r.push_back(mk(0,0,0,0,0,1, 0,0,1,1,0));
    r.push_back(mk(0,0,1,0,0,1, 0,0,0,0,0));
    r.push_back(mk(0,1,0,0,0,1, 1,0,1,0,0));
    r.push_back(mk(0,1,0,0,0,15, 0,0,0,1,0));
    r.push_back(mk(0,1,0,0,0,15, 1,0,1,0,0)); // start honoured while done visible
    r.push_back(mk(0,0,1,0,0,15, 0,0,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); e = exp_q.pop_front(); o = {start_ack, err, busy, done, count};
      total++;
      if (o !== e) begin bad++; $display("FAIL boundary step %0d got(ack,err,busy,done,cnt)=%b want=%b", i, o, e); end
    end
  endtask

`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
  task automatic test_prescale();
    row_t r[$]; obs_t e, o;
    prescale = 8'd2;
    r.push_back(mk(0,1,0,0,0,2, 1,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,2, 0,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,2, 0,0,1,0,0));
    r.push_back(mk(0,0,0,0,0,2, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,2, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,2, 0,0,1,0,1));
    r.push_back(mk(0,0,0,0,0,2, 0,0,0,1,0));
    r.push_back(mk(0,0,0,0,0,2, 0,0,0,0,0));
    foreach (r[i]) begin
      apply(r[i]); e = exp_q.pop_front(); o = {start_ack, err, busy, done, count};
      total++;
      if (o !== e) begin bad++; $display("FAIL prescale step %0d got(ack,err,busy,done,cnt)=%b want=%b", i, o, e); end
    end
    prescale = 8'd0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode_periodic = 1'b0; period = 4'd0;
    @(posedge clk); #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_boundaries();
`ifdef COUNTER_SEQ_CTRL_PRESCALE_EN
    test_prescale();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
